// File: rtl/mini_src_pkg.sv
// Shared constants for the Mini SRC display path: digit count, blank pattern
// and the active-low hex-to-segment table ({g,f,e,d,c,b,a}, index = nibble).
package mini_src_pkg;

   localparam int DIGITS = 8;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [15:0][6:0] HEX_SEG = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low seven-segment decoder; zero latency,
// no flow control.
module hex_to_7seg
   import mini_src_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/out_port_display.sv
// Scans the output-port word onto eight multiplexed hex digits, one digit per
// CLK_DIV cycles; new data waits for a frame boundary and update is never refused.
module out_port_display
#(
   parameter int CLK_DIV = 50000,
   parameter int DIGITS  = 8
)
(
   input  logic              clock,
   input  logic              clear,
   input  logic [31:0]       OutPortData,
   input  logic              update,
   input  logic              blank_lz,
   input  logic [DIGITS-1:0] dp_mask,
   output logic [6:0]        seg_n,
   output logic              dp_n,
   output logic [DIGITS-1:0] an_n,
   output logic              frame
);
   import mini_src_pkg::SEG_BLANK;

   localparam int PW = $clog2(CLK_DIV);

   logic [PW-1:0] p;
   logic [2:0]    idx;
   logic [31:0]   disp;
   logic [31:0]   pend;
   logic          pv;

   logic          tick;
   logic          boundary;
   logic [2:0]    nidx;
   logic [31:0]   ndisp;
   logic [3:0]    nib;
   logic [6:0]    hex_seg;
   logic          lz;

   assign tick     = (p == PW'(CLK_DIV - 1));
   assign boundary = tick && (idx == 3'd7);
   assign nidx     = tick ? idx + 3'd1 : idx;

   // An update landing on the boundary edge bypasses pend and shows at once.
   always_comb begin
      ndisp = disp;
      if (boundary) begin
         if (update)
            ndisp = OutPortData;
         else if (pv)
            ndisp = pend;
      end
   end

   assign nib = ndisp[{nidx, 2'b00} +: 4];
   assign lz  = blank_lz && (nidx != 3'd0) && ((ndisp >> {nidx, 2'b00}) == 32'd0);

   hex_to_7seg u_hex (
      .nibble (nib),
      .seg_n  (hex_seg)
   );

   always_ff @(posedge clock) begin
      if (clear) begin
         p     <= '0;
         idx   <= 3'd7;
         disp  <= '0;
         pend  <= '0;
         pv    <= 1'b0;
         seg_n <= SEG_BLANK;
         dp_n  <= 1'b1;
         an_n  <= '1;
         frame <= 1'b0;
      end else begin
         p     <= tick ? '0 : p + PW'(1);
         idx   <= nidx;
         disp  <= ndisp;
         frame <= boundary;

         if (boundary)
            pv <= 1'b0;
         else if (update) begin
            pend <= OutPortData;
            pv   <= 1'b1;
         end

         // Outputs only move on a tick, so blank_lz/dp_mask changes wait for it.
         if (tick) begin
            if (lz) begin
               an_n  <= '1;
               seg_n <= SEG_BLANK;
               dp_n  <= 1'b1;
            end else begin
               an_n  <= ~(DIGITS'(1) << nidx);
               seg_n <= hex_seg;
               dp_n  <= ~dp_mask[nidx];
            end
         end
      end
   end

endmodule

// File: tb/tb_out_port_display.sv
// Directed plus random stimulus for out_port_display at CLK_DIV = 4, checked
// against a cycle-count based model of the display schedule.
module tb_out_port_display;

   localparam int CD = 4;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] OutPortData;
   logic        update;
   logic        blank_lz;
   logic [7:0]  dp_mask;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [7:0]  an_n;
   logic        frame;

   int vectors = 0;
   int miscompares = 0;

   // model state: edges since clear released, shown word, latest pending word
   int          ecount;
   logic [31:0] m_disp, m_pend;
   bit          m_pv;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [7:0]  e_an;
   logic        e_frame;

   out_port_display #(.CLK_DIV(CD), .DIGITS(8)) dut (
      .clock       (clock),
      .clear       (clear),
      .OutPortData (OutPortData),
      .update      (update),
      .blank_lz    (blank_lz),
      .dp_mask     (dp_mask),
      .seg_n       (seg_n),
      .dp_n        (dp_n),
      .an_n        (an_n),
      .frame       (frame)
   );

   always #5 clock = ~clock;

   function automatic logic [6:0] hexseg(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance the model by one rising edge using the inputs that edge sampled.
   task automatic model_edge();
      int d;
      bit tick, bnd;
      if (clear) begin
         ecount = 0; m_disp = 0; m_pend = 0; m_pv = 0;
         e_seg = 7'h7F; e_dp = 1'b1; e_an = 8'hFF; e_frame = 1'b0;
         return;
      end
      ecount++;
      tick = (ecount % CD) == 0;
      bnd  = (ecount % (8 * CD)) == CD;
      if (bnd) begin
         if (update) m_disp = OutPortData;
         else if (m_pv) m_disp = m_pend;
         m_pv = 0;
      end else if (update) begin
         m_pend = OutPortData;
         m_pv = 1;
      end
      e_frame = bnd;
      if (tick) begin
         d = ((ecount / CD) - 1) % 8;
         if (blank_lz && d != 0 && (m_disp >> (4 * d)) == 32'd0) begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
         end else begin
            e_an  = ~(8'd1 << d);
            e_seg = hexseg(m_disp[4*d +: 4]);
            e_dp  = ~dp_mask[d];
         end
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      model_edge();
      #1;
      chk("an_n",  {24'd0, an_n},  {24'd0, e_an});
      chk("seg_n", {25'd0, seg_n}, {25'd0, e_seg});
      chk("dp_n",  {31'd0, dp_n},  {31'd0, e_dp});
      chk("frame", {31'd0, frame}, {31'd0, e_frame});
      update = 1'b0;
      clear  = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic run_until_frame();
      for (int i = 0; i < 8 * CD + 2; i++) begin
         cyc();
         if (e_frame) break;
      end
   endtask

   task automatic upd(input logic [31:0] v);
      OutPortData = v;
      update = 1'b1;
      cyc();
   endtask

   initial begin
      clear = 1'b1; update = 1'b0; OutPortData = 32'd0; blank_lz = 1'b0; dp_mask = 8'h00;
      ecount = 0; m_disp = 0; m_pend = 0; m_pv = 0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 8'hFF; e_frame = 1'b0;

      // reset and first boundary
      clear = 1'b1; cyc();
      clear = 1'b1; cyc();
      run(3);
      chk("rst_an", {24'd0, an_n}, 32'hFF);
      chk("rst_seg", {25'd0, seg_n}, 32'h7F);
      cyc();
      chk("first_frame", {31'd0, frame}, 32'd1);
      chk("first_an", {24'd0, an_n}, 32'hFE);
      chk("first_seg", {25'd0, seg_n}, 32'h40);

      // mid-frame update stays hidden until the next frame
      run(5);
      upd(32'h12345678);
      run_until_frame();
      chk("mid_d0_an", {24'd0, an_n}, 32'hFE);
      chk("mid_d0_seg", {25'd0, seg_n}, 32'h00);
      run(7 * CD);
      chk("mid_d7_an", {24'd0, an_n}, 32'h7F);
      chk("mid_d7_seg", {25'd0, seg_n}, 32'h79);

      // leading-zero blanking
      blank_lz = 1'b1;
      run(2);
      upd(32'h000000A0);
      run_until_frame();
      chk("lz_d0_seg", {25'd0, seg_n}, 32'h40);
      run(CD);
      chk("lz_d1_seg", {25'd0, seg_n}, 32'h08);
      run(CD);
      chk("lz_d2_an", {24'd0, an_n}, 32'hFF);
      chk("lz_d2_seg", {25'd0, seg_n}, 32'h7F);
      upd(32'h00000000);
      run_until_frame();
      run(CD);
      chk("zero_d1_an", {24'd0, an_n}, 32'hFF);
      run_until_frame();
      blank_lz = 1'b0;

      // update coinciding with the boundary edge
      for (int i = 0; i < 8 * CD && ((ecount + 1) % (8 * CD)) != CD; i++) cyc();
      upd(32'hFFFFFFFF);
      chk("bnd_frame", {31'd0, frame}, 32'd1);
      chk("bnd_seg", {25'd0, seg_n}, 32'h0E);

      // last of two updates in one frame wins
      run(3);
      upd(32'h11111111);
      run(4);
      upd(32'h22222222);
      run_until_frame();
      chk("two_upd_seg", {25'd0, seg_n}, 32'h24);

      // decimal point on digit 0 only
      dp_mask = 8'h01;
      run_until_frame();
      run_until_frame();
      chk("dp_d0", {31'd0, dp_n}, 32'd0);
      run(CD);
      chk("dp_d1", {31'd0, dp_n}, 32'd1);

      // clear at idx 4 with data pending
      dp_mask = 8'h00;
      run_until_frame();
      run(3);
      upd(32'hABCDEF01);
      run(4 * CD - 4);
      clear = 1'b1; cyc();
      chk("clr_an", {24'd0, an_n}, 32'hFF);
      chk("clr_seg", {25'd0, seg_n}, 32'h7F);
      run_until_frame();
      chk("clr_d0_seg", {25'd0, seg_n}, 32'h40);
      run(7 * CD);
      chk("clr_d7_seg", {25'd0, seg_n}, 32'h40);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 49) == 0) blank_lz = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 49) == 0) dp_mask = 8'($urandom);
         if ($urandom_range(0, 299) == 0) clear = 1'b1;
         if ($urandom_range(0, 7) == 0) begin
            update = 1'b1;
            OutPortData = $urandom >> $urandom_range(0, 31);
         end
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
